// File: rtl/tron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tron_pkg
// Description : Shared types, constants and helpers for the light-cycle
//               motion stage (directions, FSM states, arena limits, winners).
// Revision    : 1.0 - initial release
// ============================================================================
package tron_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int CELL_PX = 4;
    localparam int X_MAX   = 636;
    localparam int Y_MAX   = 476;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Signed coordinate wide enough that stepping off the low edge goes
    // negative instead of wrapping to a large legal-looking value.
    typedef struct packed {
        logic signed [10:0] x;
        logic signed [10:0] y;
    } cand_t;

    // Opposite heading: flipping the upper bit swaps UP/DOWN and RIGHT/LEFT.
    function automatic dir_t dir_reverse(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    function automatic cand_t to_cand(input logic [9:0] x, input logic [9:0] y);
        cand_t c;
        c.x = $signed({1'b0, x});
        c.y = $signed({1'b0, y});
        return c;
    endfunction

    // Position one grid cell further along heading d.
    function automatic cand_t advance(input logic [9:0] x, input logic [9:0] y,
                                      input dir_t d);
        cand_t c;
        c = to_cand(x, y);
        case (d)
            DIR_UP:    c.y = c.y - $signed(11'(CELL_PX));
            DIR_RIGHT: c.x = c.x + $signed(11'(CELL_PX));
            DIR_DOWN:  c.y = c.y + $signed(11'(CELL_PX));
            default:   c.x = c.x - $signed(11'(CELL_PX));
        endcase
        return c;
    endfunction

    function automatic logic in_arena(input cand_t c);
        return (c.x >= 11'sd0) && (c.x <= $signed(11'(X_MAX))) &&
               (c.y >= 11'sd0) && (c.y <= $signed(11'(Y_MAX)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_timer.sv
`default_nettype none
// ============================================================================
// Module      : step_timer
// Description : Free-running movement step counter; tick marks the last
//               cycle of each step while run is high, held at 0 otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module step_timer #(
    parameter int STEP_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] count;

    // Count 0..STEP_CYCLES-1 while running; park at 0 when not running.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (!run || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = run && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/player_motion.sv
`default_nettype none
// ============================================================================
// Module      : player_motion
// Description : Game state and both light-cycle heads: direction latching,
//               per-step movement, wall / head-on / trace crash detection and
//               the trace write strobe toward the trace drawer.
// Revision    : 1.0 - initial release
// ============================================================================
module player_motion
    import tron_pkg::*;
#(
    parameter int STEP_CYCLES = 1_000_000,
    parameter int P1_X0       = 40,
    parameter int P1_Y0       = 240,
    parameter int P2_X0       = 600,
    parameter int P2_Y0       = 240
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  dir_t       p1_dir,
    input  dir_t       p2_dir,
    input  logic       p1_dir_vld,
    input  logic       p2_dir_vld,
    input  logic       collided,
    output logic [9:0] new_x1,
    output logic [9:0] new_y1,
    output logic [9:0] new_x2,
    output logic [9:0] new_y2,
    output logic       en_cond,
    output logic       game_over,
    output logic [1:0] winner
);

    state_t state;
    dir_t   head1, head2;
    dir_t   pend1, pend2;
    dir_t   eff1, eff2;
    logic   tick;
    cand_t  cand1, cand2, pos1, pos2;
    logic   ok1, ok2, head_on;

    step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clock (clock),
        .reset (reset),
        .run   (state == ST_RUN),
        .tick  (tick)
    );

    // Effective direction this cycle: a same-cycle request beats the stored
    // one, but never a reversal of the heading currently being travelled.
    always_comb begin
        eff1 = pend1;
        eff2 = pend2;
        if (p1_dir_vld && (p1_dir != dir_reverse(head1))) eff1 = p1_dir;
        if (p2_dir_vld && (p2_dir != dir_reverse(head2))) eff2 = p2_dir;
    end

    // Candidate positions and the crash conditions they imply.
    always_comb begin
        pos1    = to_cand(new_x1, new_y1);
        pos2    = to_cand(new_x2, new_y2);
        cand1   = advance(new_x1, new_y1, eff1);
        cand2   = advance(new_x2, new_y2, eff2);
        ok1     = in_arena(cand1);
        ok2     = in_arena(cand2);
        head_on = ok1 && ok2 &&
                  ((cand1 == cand2) || ((cand1 == pos2) && (cand2 == pos1)));
    end

    // Game FSM with registered heads, strobe and result.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_IDLE;
            new_x1    <= 10'(P1_X0);
            new_y1    <= 10'(P1_Y0);
            new_x2    <= 10'(P2_X0);
            new_y2    <= 10'(P2_Y0);
            head1     <= DIR_RIGHT;
            head2     <= DIR_LEFT;
            pend1     <= DIR_RIGHT;
            pend2     <= DIR_LEFT;
            en_cond   <= 1'b0;
            game_over <= 1'b0;
            winner    <= WIN_NONE;
        end else begin
            en_cond <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pend1 <= eff1;
                    pend2 <= eff2;
                    if (start) begin
                        state   <= ST_RUN;
                        en_cond <= 1'b1;   // mark the start cells
                    end
                end
                ST_RUN: begin
                    pend1 <= eff1;
                    pend2 <= eff2;
                    if (tick) begin
                        head1 <= eff1;
                        head2 <= eff2;
                    end
                    if (tick && (!ok1 || !ok2)) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                        winner    <= {!ok1, !ok2};
                    end else if ((tick && head_on) || collided) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                        winner    <= WIN_DRAW;
                    end else if (tick) begin
                        new_x1  <= cand1.x[9:0];
                        new_y1  <= cand1.y[9:0];
                        new_x2  <= cand2.x[9:0];
                        new_y2  <= cand2.y[9:0];
                        en_cond <= 1'b1;
                    end
                end
                default: begin
                    // OVER: everything frozen until reset.
                    state     <= ST_OVER;
                    game_over <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_player_motion.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_motion
// Description : Self-checking bench for player_motion against a behavioural
//               game model, plus literal expectations for key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_motion;
    import tron_pkg::*;

    localparam int STEP = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, start, p1_vld, p2_vld, collided;
    dir_t p1_dir, p2_dir;
    logic [9:0] x1, y1, x2, y2;
    logic en, go;
    logic [1:0] win;

    logic reset_b, start_b;
    dir_t dir_b;
    logic vld_b;
    logic [9:0] bx1, by1, bx2, by2;
    logic ben, bgo;
    logic [1:0] bwin;

    int checks = 0;
    int errors = 0;

    player_motion #(.STEP_CYCLES(STEP)) dut (
        .clock(clock), .reset(reset), .start(start),
        .p1_dir(p1_dir), .p2_dir(p2_dir), .p1_dir_vld(p1_vld), .p2_dir_vld(p2_vld),
        .collided(collided),
        .new_x1(x1), .new_y1(y1), .new_x2(x2), .new_y2(y2),
        .en_cond(en), .game_over(go), .winner(win)
    );

    // Heads one cell apart facing each other: first step swaps them.
    player_motion #(.STEP_CYCLES(STEP), .P1_X0(300), .P1_Y0(240),
                    .P2_X0(304), .P2_Y0(240)) dut_b (
        .clock(clock), .reset(reset_b), .start(start_b),
        .p1_dir(dir_b), .p2_dir(dir_b), .p1_dir_vld(vld_b), .p2_dir_vld(vld_b),
        .collided(1'b0),
        .new_x1(bx1), .new_y1(by1), .new_x2(bx2), .new_y2(by2),
        .en_cond(ben), .game_over(bgo), .winner(bwin)
    );

    // ---------------- behavioural model ----------------
    int m_x1, m_y1, m_x2, m_y2;
    int m_h1, m_h2, m_p1, m_p2;
    int m_cnt, m_phase;          // phase: 0 waiting, 1 playing, 2 finished
    int m_en, m_win;

    function automatic int dx(input int d);
        return (d == 1) ? 4 : (d == 3) ? -4 : 0;
    endfunction
    function automatic int dy(input int d);
        return (d == 0) ? -4 : (d == 2) ? 4 : 0;
    endfunction
    function automatic bit off_board(input int x, input int y);
        return (x < 0) || (x > 636) || (y < 0) || (y > 476);
    endfunction

    task automatic model_edge();
        int e1, e2, cx1, cy1, cx2, cy2;
        bit out1, out2, tk;
        if (!reset) begin
            m_x1 = 40; m_y1 = 240; m_x2 = 600; m_y2 = 240;
            m_h1 = 1; m_h2 = 3; m_p1 = 1; m_p2 = 3;
            m_cnt = 0; m_phase = 0; m_en = 0; m_win = 0;
            return;
        end
        m_en = 0;
        if (m_phase == 2) return;
        e1 = m_p1;
        e2 = m_p2;
        if (p1_vld && (int'(p1_dir) != (m_h1 ^ 2))) e1 = int'(p1_dir);
        if (p2_vld && (int'(p2_dir) != (m_h2 ^ 2))) e2 = int'(p2_dir);
        m_p1 = e1;
        m_p2 = e2;
        if (m_phase == 0) begin
            if (start) begin
                m_phase = 1; m_en = 1; m_cnt = 0;
            end
            return;
        end
        tk = (m_cnt == STEP - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        if (tk) begin
            m_h1 = e1; m_h2 = e2;
            cx1 = m_x1 + dx(e1); cy1 = m_y1 + dy(e1);
            cx2 = m_x2 + dx(e2); cy2 = m_y2 + dy(e2);
            out1 = off_board(cx1, cy1);
            out2 = off_board(cx2, cy2);
            if (out1 || out2) begin
                m_phase = 2;
                m_win = out1 ? (out2 ? 3 : 2) : 1;
            end else if ((cx1 == cx2 && cy1 == cy2) ||
                         (cx1 == m_x2 && cy1 == m_y2 && cx2 == m_x1 && cy2 == m_y1) ||
                         collided) begin
                m_phase = 2; m_win = 3;
            end else begin
                m_x1 = cx1; m_y1 = cy1; m_x2 = cx2; m_y2 = cy2; m_en = 1;
            end
        end else if (collided) begin
            m_phase = 2; m_win = 3;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("x1", int'(x1), m_x1);
        chk("y1", int'(y1), m_y1);
        chk("x2", int'(x2), m_x2);
        chk("y2", int'(y2), m_y2);
        chk("en_cond", int'(en), m_en);
        chk("game_over", int'(go), (m_phase == 2) ? 1 : 0);
        chk("winner", int'(win), m_win);
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic quiet();
        start = 0; p1_vld = 0; p2_vld = 0; collided = 0; reset = 1;
    endtask

    task automatic new_game();
        quiet();
        reset = 0; cycle(); reset = 1;
        start = 1; cycle(); start = 0;
    endtask

    task automatic wait_en(input string name, input int bound);
        int n = 0;
        while (!en && n < bound) begin cycle(); n++; end
        if (!en) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_over(input string name, input int bound);
        int n = 0;
        while (!go && n < bound) begin cycle(); n++; end
        if (!go) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        reset_b = 0; start_b = 0; dir_b = DIR_UP; vld_b = 0;
        p1_dir = DIR_UP; p2_dir = DIR_UP;
        quiet();

        // Reset values
        reset = 0; cycle(); cycle();
        chk("rst_x1", int'(x1), 40);  chk("rst_x2", int'(x2), 600);
        chk("rst_en", int'(en), 0);   chk("rst_win", int'(win), 0);
        chk("rst_go", int'(go), 0);

        // Start marks the start cells, first step after STEP cycles
        reset = 1; start = 1; cycle(); start = 0;
        chk("start_en", int'(en), 1); chk("start_x1", int'(x1), 40);
        chk("start_x2", int'(x2), 600);
        repeat (3) cycle();
        chk("pre_step_en", int'(en), 0);
        cycle();
        chk("step1_x1", int'(x1), 44); chk("step1_x2", int'(x2), 596);
        chk("step1_en", int'(en), 1);
        cycle();
        chk("step1_en_drop", int'(en), 0);

        // Reverse request ignored, then UP turns P1
        p1_dir = DIR_LEFT; p1_vld = 1; cycle(); p1_vld = 0;
        wait_en("rev", 10);
        chk("rev_x1", int'(x1), 48); chk("rev_y1", int'(y1), 240);
        cycle();
        p1_dir = DIR_UP; p1_vld = 1; cycle(); p1_vld = 0;
        wait_en("up", 10);
        chk("up_y1", int'(y1), 236); chk("up_x1", int'(x1), 48);

        // Wall crash off the top edge
        new_game();
        p1_dir = DIR_UP; p1_vld = 1; cycle(); p1_vld = 0;
        wait_over("wall", 400);
        chk("wall_win", int'(win), 2); chk("wall_y1", int'(y1), 0);
        chk("wall_en", int'(en), 0);
        repeat (3) cycle();

        // Straight head-on: equal candidates at 320
        new_game();
        wait_over("headon", 400);
        chk("headon_win", int'(win), 3);
        chk("headon_x1", int'(x1), 316); chk("headon_x2", int'(x2), 324);

        // Trace collision mid-step, then OVER ignores start and requests
        new_game();
        cycle(); collided = 1; cycle(); collided = 0;
        chk("coll_go", int'(go), 1); chk("coll_win", int'(win), 3);
        start = 1; p1_dir = DIR_UP; p1_vld = 1; p2_dir = DIR_DOWN; p2_vld = 1;
        repeat (10) cycle();
        quiet();
        chk("coll_x1", int'(x1), 40); chk("coll_y1", int'(y1), 240);

        // Reset mid-run
        new_game();
        repeat (6) cycle();
        reset = 0; cycle(); reset = 1;
        chk("midrst_en", int'(en), 0); chk("midrst_x1", int'(x1), 40);
        chk("midrst_go", int'(go), 0);
        cycle();

        // Randomised games against the model
        for (int g = 0; g < 12; g++) begin
            new_game();
            for (int i = 0; i < 320; i++) begin
                p1_vld = ($urandom_range(0, 5) == 0);
                p2_vld = ($urandom_range(0, 5) == 0);
                p1_dir = dir_t'($urandom_range(0, 3));
                p2_dir = dir_t'($urandom_range(0, 3));
                collided = ($urandom_range(0, 299) == 0);
                start = ($urandom_range(0, 7) == 0);
                reset = ($urandom_range(0, 499) != 0);
                cycle();
            end
            quiet();
        end

        // Swap case on the second instance
        reset_b = 1; start_b = 1;
        @(posedge clock); #1;
        start_b = 0;
        chk("swap_start_en", int'(ben), 1);
        repeat (4) @(posedge clock);
        #1;
        chk("swap_go", int'(bgo), 1); chk("swap_win", int'(bwin), 3);
        chk("swap_x1", int'(bx1), 300); chk("swap_en", int'(ben), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_motion.md
# player_motion

Upstream stage of the trace drawer. Owns game state and both light-cycle heads. It latches direction requests, advances each head one 4-px grid cell per step tick, and detects wall and head-on crashes. It drives new_x1/new_y1/new_x2/new_y2 and a one-cycle en_cond write strobe into the trace drawer, and consumes that drawer's sticky collided flag to end the game.

## Interface
- STEP_CYCLES, 1_000_000: clock cycles per movement step (≥2)
- P1_X0 / P1_Y0, 40 / 240: player 1 start pixel (multiple of 4)
- P2_X0 / P2_Y0, 600 / 240: player 2 start pixel (multiple of 4)
- clock  in  1  system clock; the only clock
- reset  in  1  synchronous, active-low (0 = reset)
- start  in  1  level; sampled in IDLE only
- p1_dir, p2_dir  in  2 each  requested direction (dir_t)
- p1_dir_vld, p2_dir_vld  in  1 each  request strobe; one cycle high latches the request
- collided  in  1  sticky trace-collision flag from the trace drawer
- new_x1, new_y1, new_x2, new_y2  out  10 each  head pixel coordinates; always a multiple of 4
- en_cond  out  1  one-cycle trace write strobe
- game_over  out  1  high in OVER
- winner  out  2  2'b01 P1 wins, 2'b10 P2 wins, 2'b11 draw, 2'b00 undecided

## Operation
- Reset (reset==0): state IDLE; heads at P1_X0/P1_Y0 and P2_X0/P2_Y0; P1 heading RIGHT, P2 heading LEFT; pending directions equal to the headings; step counter 0; en_cond=0; game_over=0; winner=00.
- Direction encoding: UP=0, RIGHT=1, DOWN=2, LEFT=3. The reverse of d is d^2'b10.
- Direction latch: in IDLE and RUN, a valid request updates pending_dir unless the request equals the reverse of the current heading. Ignored requests leave pending_dir unchanged. The last valid request before a tick wins.
- IDLE → RUN when start==1. In the first RUN cycle, en_cond=1 with the start positions, which marks the start cells.
- RUN:
  - The step counter counts 0..STEP_CYCLES-1 and wraps.
  - tick is high when the counter equals STEP_CYCLES-1.
  - On tick: heading ← pending_dir, and each head's candidate position is head ± 4 along its heading.
- Wall check on tick. Legal x range is 0..636 and legal y range is 0..476. Arithmetic uses 11-bit signed, so 0−4 is detected as out of range and does not wrap to 1020.
  - A player whose candidate is out of range crashes.
  - Only P1 crashes: winner=10. Only P2 crashes: winner=01. Both crash: winner=11.
  - On any crash: go to OVER, positions hold at their last legal values, and no en_cond is issued.
- Head-on check on tick. If both candidates are in range and equal, or the two heads swap cells, winner=11 and go to OVER with no write.
- Otherwise, on tick the heads take their candidate positions, and en_cond=1 in the following cycle.
- If collided==1 in any RUN cycle: go to OVER with winner=11 (the flag does not say which player). Wall and head-on results take priority when they occur on the same cycle.
- OVER: game_over=1; winner, positions and headings frozen; en_cond=0. Ignores start and direction requests. Only reset leaves OVER.

## Timing
- Cycle T is the tick cycle. The head registers show the new positions from T+1, and en_cond=1 in exactly cycle T+1. The positions stay stable for at least STEP_CYCLES−1 cycles after that.
- en_cond is never high on two consecutive cycles.
- The crash decision is made in cycle T. State reads OVER and game_over=1 from T+1.
- collided sampled in cycle C: OVER from C+1.
- The step counter is held at 0 in IDLE and OVER. It restarts at 0 on entry to RUN, so the first tick comes STEP_CYCLES cycles after the entry cycle.
- A direction request and a tick in the same cycle: the request applies to this step, subject to the reverse check against the pre-tick heading.
- Reset mid-RUN: full reset on the next edge; en_cond is 0 in the cycle after.

## Structure
- tron_pkg holds:
  - dir_t (2-bit enum) and the reverse rule
  - state_t {IDLE, RUN, OVER}
  - constants CELL_PX=4, X_MAX=636, Y_MAX=476
  - winner codes
- Sub-module step_timer (STEP_CYCLES; ports clock, reset, run, tick) owns the counter.
- Direction latch, next-position arithmetic, crash logic and FSM live in player_motion.

## Test plan
All scenarios use STEP_CYCLES=4.
- Reset, start=1: en_cond pulses in the first RUN cycle with (40,240)/(600,240). After 4 cycles, heads at (44,240)/(596,240) with en_cond high for exactly 1 cycle.
- P1 requests LEFT while heading RIGHT: request ignored, P1 keeps moving +4 in x. P1 requests UP: next step moves P1 to y=236.
- P1 heading UP from y=0 on tick: game_over=1, winner=10, new_y1 stays 0, no en_cond.
- Heads at (300,240)/(308,240) facing each other: next tick gives equal candidates (304,240), so winner=11 with no write. Heads one cell apart and facing: they swap cells, so winner=11.
- collided asserted mid-step in RUN: OVER next cycle, winner=11; later start pulses and direction requests are ignored.
- reset=0 mid-RUN for one cycle: all outputs return to reset values, state IDLE, en_cond 0.
